// File: rtl/uart_bus_master.sv
// UART command bridge: 'W'/'R' byte commands from an AXI-Stream RX link drive one
// native memory-bus transaction each and answer with status/read bytes on the TX link.
module uart_bus_master #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  input_axis_tdata,
  input  logic        input_axis_tvalid,
  output logic        input_axis_tready,
  output logic [7:0]  output_axis_tdata,
  output logic        output_axis_tvalid,
  input  logic        output_axis_tready,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  // Handshakes: a stream byte moves on any rising edge where tvalid && tready;
  // a source keeps tvalid/tdata steady until then. The bus request stays up with
  // stable addr/wdata/wstrb until the first edge with mem_valid && mem_ready.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [7:0]  CMD_WRITE = 8'h57;
  localparam logic [7:0]  CMD_READ  = 8'h52;
  localparam logic [7:0]  RSP_OK    = 8'h4B;
  localparam logic [7:0]  RSP_TMO   = 8'h54;
  localparam logic [7:0]  RSP_BAD   = 8'h3F;
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_byte_cnt;
  logic        r_is_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_mem_valid;
  logic [15:0] r_tmo_cnt;
  logic [31:0] r_rdata;
  logic [7:0]  r_tdata;
  logic        r_tvalid;
  logic [2:0]  r_resp_idx;
  logic [2:0]  r_resp_len;

  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_last_byte;
  logic        w_mem_done;
  logic        w_timeout;
  logic        w_resp_last;
  logic        w_is_cmd;
  logic [7:0]  w_rdata_byte;

  assign input_axis_tready  = !rst && (r_state == S_IDLE || r_state == S_ADDR ||
                                       r_state == S_DATA);
  assign output_axis_tdata  = r_tdata;
  assign output_axis_tvalid = r_tvalid;
  assign mem_valid          = r_mem_valid;
  assign mem_instr          = 1'b0;
  assign mem_addr           = {r_addr[31:2], 2'b00};
  assign mem_wdata          = r_wdata;
  assign mem_wstrb          = r_wstrb;
  assign busy               = (r_state != S_IDLE);

  assign w_in_fire   = input_axis_tvalid && input_axis_tready;
  assign w_out_fire  = r_tvalid && output_axis_tready;
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_is_cmd    = (input_axis_tdata == CMD_WRITE) || (input_axis_tdata == CMD_READ);
  // Completion is checked first so a ready in the final counted cycle wins.
  assign w_mem_done  = r_mem_valid && mem_ready;
  assign w_timeout   = r_mem_valid && !mem_ready && (r_tmo_cnt == TMO_LAST);
  assign w_resp_last = (r_resp_idx == r_resp_len - 3'd1);

  always_comb begin
    w_rdata_byte = r_rdata[7:0];
    case (r_resp_idx[1:0])
      2'd0:    w_rdata_byte = r_rdata[7:0];
      2'd1:    w_rdata_byte = r_rdata[15:8];
      2'd2:    w_rdata_byte = r_rdata[23:16];
      default: w_rdata_byte = r_rdata[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_in_fire) begin
          w_next = w_is_cmd ? S_ADDR : S_RESP;
        end
      end
      S_ADDR: begin
        if (w_in_fire && w_last_byte) begin
          w_next = r_is_write ? S_DATA : S_BUS;
        end
      end
      S_DATA: begin
        if (w_in_fire && w_last_byte) begin
          w_next = S_BUS;
        end
      end
      S_BUS: begin
        if (w_mem_done || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (w_out_fire && w_resp_last) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt  <= 2'd0;
      r_is_write  <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_mem_valid <= 1'b0;
      r_tmo_cnt   <= 16'd0;
      r_rdata     <= 32'd0;
      r_tdata     <= 8'd0;
      r_tvalid    <= 1'b0;
      r_resp_idx  <= 3'd0;
      r_resp_len  <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_fire) begin
            r_byte_cnt <= 2'd0;
            if (w_is_cmd) begin
              r_is_write <= (input_axis_tdata == CMD_WRITE);
            end else begin
              r_tdata    <= RSP_BAD;
              r_tvalid   <= 1'b1;
              r_resp_idx <= 3'd0;
              r_resp_len <= 3'd1;
            end
          end
        end
        S_ADDR: begin
          if (w_in_fire) begin
            r_addr     <= {input_axis_tdata, r_addr[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte && !r_is_write) begin
              r_mem_valid <= 1'b1;
              r_wstrb     <= 4'b0000;
              r_tmo_cnt   <= 16'd0;
            end
          end
        end
        S_DATA: begin
          if (w_in_fire) begin
            r_wdata    <= {input_axis_tdata, r_wdata[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              r_mem_valid <= 1'b1;
              r_wstrb     <= 4'b1111;
              r_tmo_cnt   <= 16'd0;
            end
          end
        end
        S_BUS: begin
          if (w_mem_done) begin
            r_mem_valid <= 1'b0;
            r_rdata     <= mem_rdata;
            r_tdata     <= RSP_OK;
            r_tvalid    <= 1'b1;
            r_resp_idx  <= 3'd0;
            r_resp_len  <= r_is_write ? 3'd1 : 3'd5;
          end else if (w_timeout) begin
            r_mem_valid <= 1'b0;
            r_tdata     <= RSP_TMO;
            r_tvalid    <= 1'b1;
            r_resp_idx  <= 3'd0;
            r_resp_len  <= 3'd1;
          end else if (r_mem_valid) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
        S_RESP: begin
          // Byte 0 is the status; read data follows LSB first.
          if (w_out_fire) begin
            if (w_resp_last) begin
              r_tvalid   <= 1'b0;
              r_resp_idx <= 3'd0;
            end else begin
              r_tdata    <= w_rdata_byte;
              r_resp_idx <= r_resp_idx + 3'd1;
            end
          end
        end
        default: begin
          r_mem_valid <= 1'b0;
          r_tvalid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 1024: maximum cycles mem_valid is held without mem_ready before the transaction aborts; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 input_axis_tdata  input  8  command byte from UART RX.
REQ-005 input_axis_tvalid  input  1  command byte valid.
REQ-006 input_axis_tready  output  1  block accepts the byte this cycle.
REQ-007 output_axis_tdata  output  8  response byte to UART TX.
REQ-008 output_axis_tvalid  output  1  response byte valid.
REQ-009 output_axis_tready  input  1  UART TX accepts the byte.
REQ-010 mem_valid  output  1  bus request, initiator side of the native memory interface.
REQ-011 mem_instr  output  1  constant 0.
REQ-012 mem_ready  input  1  responder completion strobe.
REQ-013 mem_addr  output  32  word address; bits [1:0] always 0.
REQ-014 mem_wdata  output  32  write data.
REQ-015 mem_wstrb  output  4  4'b1111 for writes, 4'b0000 for reads.
REQ-016 mem_rdata  input  32  read data, valid in the mem_ready cycle.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 States: IDLE, ADDR, DATA, BUS, RESP.
REQ-019 A byte transfers on a cycle with tvalid && tready on the respective stream.
REQ-020 input_axis_tready is high in IDLE, ADDR, and DATA; it is low in BUS and RESP and while rst is high.
REQ-021 In IDLE, byte 0x57 ('W') selects write and byte 0x52 ('R') selects read; either moves the block to ADDR with byte count 0.
REQ-022 In IDLE, any other byte loads response 0x3F ('?') and moves the block to RESP.
REQ-023 ADDR accepts 4 bytes, LSB first, into the address register; after the 4th byte, a write goes to DATA and a read goes to BUS.
REQ-024 DATA accepts 4 bytes, LSB first, into the write-data register; after the 4th byte, the block goes to BUS.
REQ-025 Entering BUS asserts mem_valid on the next cycle, with mem_addr = {addr[31:2], 2'b00}, mem_wdata, and mem_wstrb per REQ-015.
REQ-026 mem_addr, mem_wdata, and mem_wstrb are held stable for the whole time mem_valid is high.
REQ-027 On the first cycle mem_valid && mem_ready, mem_valid is low the next cycle and mem_rdata is captured in that same cycle.
REQ-028 A completed write responds with the single byte 0x4B ('K').
REQ-029 A completed read responds with 5 bytes: 0x4B, then rdata[7:0], [15:8], [23:16], [31:24].
REQ-030 The timeout counter clears on entry to BUS and increments every cycle that mem_valid is high and mem_ready is low.
REQ-031 When the counter reaches TIMEOUT, mem_valid drops the next cycle and the response is the single byte 0x54 ('T').
REQ-032 If mem_ready arrives in the same cycle the counter reaches TIMEOUT, completion wins and no 'T' is sent.
REQ-033 In RESP, output_axis_tvalid is held high with tdata stable until tready; the byte index advances only on a transfer.
REQ-034 After the last response byte transfers, the block returns to IDLE on the next cycle.
REQ-035 A mem_ready pulse while mem_valid is low is ignored.
REQ-036 Input bytes are never dropped by the block: a byte is either accepted via tready or left pending at the source.
REQ-037 Back-to-back commands are legal; the first byte of the next command is accepted the cycle after the block returns to IDLE.

Reset
REQ-038 On a clock edge with rst high, the following are reset: state=IDLE, byte counters=0, timeout counter=0, mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, output_axis_tvalid=0, output_axis_tdata=0, busy=0.
REQ-039 Reset in any state, including mid-BUS, drops mem_valid at that edge and discards any partial command and pending response.

Verification
REQ-040 Write: bytes 57 10 00 00 00 EF BE AD DE -> one bus cycle with addr 0x00000010, wdata 0xDEADBEEF, wstrb 1111 -> response 4B.
REQ-041 Read: bytes 52 13 00 00 00; responder returns 0x12345678 after 2 cycles -> mem_addr 0x00000010, wstrb 0000 -> response 4B 78 56 34 12.
REQ-042 Timeout: TIMEOUT=8, read with mem_ready held low -> mem_valid high exactly 8 cycles, then low -> response 54; mem_ready asserted in the 8th cycle instead -> response 4B plus data.
REQ-043 Unknown byte 0xAA -> no bus activity, response 3F -> then a following 'W' command completes normally.
REQ-044 Backpressure: output_axis_tready low 20 cycles during a read response -> tvalid held, tdata stays 4B, no bytes lost, and input_axis_tready stays low throughout.
REQ-045 rst pulsed 1 cycle while mem_valid is high -> mem_valid 0 the next cycle, busy 0, no response byte, and the next command executes correctly.
